// File: rtl/exhaustive_vector_sequencer.sv
// +----------------------------------------------------------------------------+
// | exhaustive_vector_sequencer                                                |
// | Sweeps all 2^N_IN input vectors, samples a 1-bit response after SETTLE     |
// | cycles and streams (vector, response) records. SEQ_SIGNATURE_EN adds an    |
// | LFSR response signature on sig_out.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module exhaustive_vector_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            CK,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_resp,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [N_IN-1:0] rec_vec,
  output logic            rec_resp,
  output logic            rec_last
`ifdef SEQ_SIGNATURE_EN
  ,output logic [15:0]    sig_out
`endif
);

  localparam logic [7:0]  c_cnt_init = 8'(SETTLE - 1);
  localparam logic [15:0] c_poly     = 16'h1021;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EMIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start_acc;
  logic            w_sample;
  logic            w_hs;
  logic [7:0]      r_cnt;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_rec_vec;
  logic            r_rec_valid;
  logic            r_rec_resp;
  logic            r_rec_last;
  logic            r_busy;
  logic            r_done;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_sample    = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
          w_start_acc = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_EMIT;
          w_sample    = 1'b1;
        end
      end
      S_EMIT: begin
        if (rec_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = r_rec_last ? S_DONE : S_SETTLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // vec_out only moves on a non-final handshake, so backpressure never resamples
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 8'd0;
      r_vec       <= '0;
      r_rec_vec   <= '0;
      r_rec_valid <= 1'b0;
      r_rec_resp  <= 1'b0;
      r_rec_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_acc) begin
        r_vec  <= '0;
        r_cnt  <= c_cnt_init;
        r_busy <= 1'b1;
      end
      if (r_state == S_SETTLE && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_sample) begin
        r_rec_resp  <= dut_resp;
        r_rec_vec   <= r_vec;
        r_rec_valid <= 1'b1;
        r_rec_last  <= &r_vec;
      end
      if (w_hs) begin
        r_rec_valid <= 1'b0;
        if (r_rec_last) begin
          r_done <= 1'b1;
        end else begin
          r_vec <= r_vec + N_IN'(1);
          r_cnt <= c_cnt_init;
        end
      end
      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign vec_out   = r_vec;
  assign rec_valid = r_rec_valid;
  assign rec_vec   = r_rec_vec;
  assign rec_resp  = r_rec_resp;
  assign rec_last  = r_rec_last;

`ifdef SEQ_SIGNATURE_EN
  logic [15:0] r_sig;

  // Galois LFSR x^16+x^12+x^5+1, one step per accepted record
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_sig <= 16'h0000;
    end else if (w_start_acc) begin
      r_sig <= 16'h0000;
    end else if (w_hs) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ ((r_sig[15] ^ r_rec_resp) ? c_poly : 16'h0000);
    end
  end

  assign sig_out = r_sig;
`else
  // Signature disabled: no LFSR state exists in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_exhaustive_vector_sequencer.sv
// Bench for exhaustive_vector_sequencer: scoreboarded sweeps with SETTLE=1 and SETTLE=4 instances.
`default_nettype none

module tb_exhaustive_vector_sequencer;

  typedef struct packed {
    logic [2:0] vec;
    logic       resp;
    logic       last;
  } rec_t;

  logic       CK = 1'b0;
  logic       reset = 1'b0;
  logic       start1 = 1'b0;
  logic       ready1 = 1'b1;
  logic       resp_zero = 1'b0;
  logic       start4 = 1'b0;
  logic       ready4 = 1'b1;
  logic [2:0] lag4 = 3'b000;

  wire        busy1, done1, valid1, rresp1, last1, resp1;
  wire  [2:0] vec1, rvec1;
  wire        busy4, done4, valid4, rresp4, last4, resp4;
  wire  [2:0] vec4, rvec4;
`ifdef SEQ_SIGNATURE_EN
  wire [15:0] sig1, sig4;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t sb[$];

  assign resp1 = resp_zero ? 1'b0 : ^vec1;
  assign resp4 = lag4[2];

  always #5 CK = ~CK;

  // Response lags the applied vector by 3 cycles
  always @(posedge CK) lag4 <= {lag4[1:0], ^vec4};

  exhaustive_vector_sequencer #(.N_IN(3), .SETTLE(1)) dut (
    .CK(CK), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .vec_out(vec1), .dut_resp(resp1), .rec_valid(valid1), .rec_ready(ready1),
    .rec_vec(rvec1), .rec_resp(rresp1), .rec_last(last1)
`ifdef SEQ_SIGNATURE_EN
    , .sig_out(sig1)
`endif
  );

  exhaustive_vector_sequencer #(.N_IN(3), .SETTLE(4)) dut4 (
    .CK(CK), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .vec_out(vec4), .dut_resp(resp4), .rec_valid(valid4), .rec_ready(ready4),
    .rec_vec(rvec4), .rec_resp(rresp4), .rec_last(last4)
`ifdef SEQ_SIGNATURE_EN
    , .sig_out(sig4)
`endif
  );

`ifdef SEQ_SIGNATURE_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  logic [15:0] sig_m;
`endif

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    n_checks++;
    if ({busy1, done1, valid1, rresp1, last1, vec1, rvec1} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000000", {busy1, done1, valid1, rresp1, last1, vec1, rvec1});
    end
    n_checks++;
    if ({busy4, done4, valid4, vec4, rvec4} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs4: got %b expected 0", {busy4, done4, valid4, vec4, rvec4});
    end
`ifdef SEQ_SIGNATURE_EN
    n_checks++;
    if (sig1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_sig: got %h expected 0000", sig1);
    end
`endif
    tick;
    reset = 1'b1;
    tick;
  endtask

  // One SETTLE=1 sweep on an XOR (or zero) DUT, optionally stalling one record
  task automatic run_sweep1(input int stall_idx, input int stall_len, input bit poke_start);
    int   idx, stall_cnt, dones, exp_c;
    bit   finished;
    rec_t r, e;
    sb.delete();
`ifdef SEQ_SIGNATURE_EN
    sig_m = 16'h0000;
`endif
    for (int v = 0; v < 8; v++) begin
      r.vec  = 3'(v);
      r.resp = resp_zero ? 1'b0 : ^r.vec;
      r.last = (v == 7);
      sb.push_back(r);
`ifdef SEQ_SIGNATURE_EN
      sig_m = lfsr_step(sig_m, r.resp);
`endif
    end
    idx = 0; stall_cnt = 0; dones = 0; finished = 1'b0;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1 || vec1 !== 3'd0) begin
      n_fail++;
      $display("FAIL start_state: got busy=%b vec=%0d expected busy=1 vec=0", busy1, vec1);
    end
    for (int c = 1; c <= 200 && !finished; c++) begin
      ready1 = 1'b1;
      if (poke_start) start1 = (c == 5);
      if (done1) begin
        dones++;
        finished = 1'b1;
        n_checks++;
        if (c != 17 + stall_len) begin
          n_fail++;
          $display("FAIL done_cycle: got %0d expected %0d", c, 17 + stall_len);
        end
        if (poke_start) start1 = 1'b1;
      end
      if (valid1) begin
        if (idx == stall_idx && stall_cnt < stall_len) begin
          ready1 = 1'b0;
          stall_cnt++;
          n_checks++;
          if (sb.size() == 0 || rvec1 !== 3'(stall_idx) || vec1 !== 3'(stall_idx) || rresp1 !== sb[0].resp) begin
            n_fail++;
            $display("FAIL stall_hold: got rec_vec=%0d vec_out=%0d resp=%b expected vec %0d held", rvec1, vec1, rresp1, stall_idx);
          end
        end else if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_record: got vec=%0d expected no record", rvec1);
        end else begin
          e = sb.pop_front();
          exp_c = 2 * (idx + 1) + ((idx >= stall_idx) ? stall_len : 0);
          n_checks++;
          if ({rvec1, rresp1, last1} !== e || c != exp_c) begin
            n_fail++;
            $display("FAIL record_%0d: got vec=%0d resp=%b last=%b cycle=%0d expected vec=%0d resp=%b last=%b cycle=%0d",
                     idx, rvec1, rresp1, last1, c, e.vec, e.resp, e.last, exp_c);
          end
          idx++;
        end
      end
      tick;
    end
    start1 = 1'b0;
    n_checks++;
    if (!finished || busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end: got finished=%b busy=%b done=%b expected 1 0 0", finished, busy1, done1);
    end
    n_checks++;
    if (idx != 8 || sb.size() != 0 || dones != 1) begin
      n_fail++;
      $display("FAIL record_count: got %0d records %0d dones expected 8 and 1", idx, dones);
    end
    if (poke_start) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0 || done1 !== 1'b0) begin
          n_fail++;
          $display("FAIL start_in_done: got busy=%b valid=%b done=%b expected 0 0 0", busy1, valid1, done1);
        end
        tick;
      end
    end
    n_checks++;
    if (vec1 !== 3'd7) begin
      n_fail++;
      $display("FAIL vec_hold: got %0d expected 7", vec1);
    end
`ifdef SEQ_SIGNATURE_EN
    n_checks++;
    if (sig1 !== sig_m) begin
      n_fail++;
      $display("FAIL signature: got %h expected %h", sig1, sig_m);
    end
`endif
  endtask

  task automatic test_basic_sweep;
    resp_zero = 1'b0;
    run_sweep1(-1, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_sweep1(3, 5, 1'b0);
  endtask

  task automatic test_start_while_busy;
    run_sweep1(-1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_sweep;
    bit found;
    found = 1'b0;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (vec1 == 3'd4 && !valid1) found = 1'b1;
      else tick;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_rec4: got timeout expected vec_out=4 in SETTLE");
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy1, done1, valid1, rresp1, last1, vec1, rvec1} !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b expected 000000000", {busy1, done1, valid1, rresp1, last1, vec1, rvec1});
    end
    tick;
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_done: got done=%b busy=%b expected 0 0", done1, busy1);
    end
    reset = 1'b1;
    tick;
    run_sweep1(-1, 0, 1'b0);
  endtask

  task automatic test_settle4;
    int   idx;
    bit   finished;
    rec_t r, e;
    sb.delete();
    for (int v = 0; v < 8; v++) begin
      r.vec  = 3'(v);
      r.resp = ^r.vec;
      r.last = (v == 7);
      sb.push_back(r);
    end
    idx = 0; finished = 1'b0;
    ready4 = 1'b1;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int c = 1; c <= 300 && !finished; c++) begin
      if (done4) begin
        finished = 1'b1;
        n_checks++;
        if (c != 41) begin
          n_fail++;
          $display("FAIL settle4_done: got cycle %0d expected 41", c);
        end
      end
      if (valid4) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL settle4_extra: got vec=%0d expected no record", rvec4);
        end else begin
          e = sb.pop_front();
          if ({rvec4, rresp4, last4} !== e || c != 5 * (idx + 1)) begin
            n_fail++;
            $display("FAIL settle4_rec_%0d: got vec=%0d resp=%b last=%b cycle=%0d expected vec=%0d resp=%b last=%b cycle=%0d",
                     idx, rvec4, rresp4, last4, c, e.vec, e.resp, e.last, 5 * (idx + 1));
          end
          idx++;
        end
      end
      tick;
    end
    n_checks++;
    if (!finished || idx != 8 || busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL settle4_end: got finished=%b records=%0d busy=%b expected 1 8 0", finished, idx, busy4);
    end
  endtask

  task automatic test_signature;
    resp_zero = 1'b0;
    run_sweep1(-1, 0, 1'b0);
    run_sweep1(-1, 0, 1'b0);
    resp_zero = 1'b1;
    run_sweep1(-1, 0, 1'b0);
    resp_zero = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic_sweep;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_sweep;
    test_settle4;
`ifdef SEQ_SIGNATURE_EN
    test_signature;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
